// File: rtl/mix_columns_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mix_columns_ctrl
//  Description : AES MixColumns sequencer. Runs 64 GF(2^8) products through
//                LANES multipliers per cycle and XOR-accumulates them into
//                the 16 output bytes. Start/done handshake; bypass copies the
//                state through unchanged for the final round.
//  Revision    : 1.0  initial release
// ============================================================================
module mix_columns_ctrl #(
    parameter int LANES = 1
) (
    input  logic         pi_clk,
    input  logic         pi_rst,
    input  logic         pi_start,
    input  logic         pi_bypass,
    input  logic [127:0] pi_state,
    output logic [127:0] po_state,
    output logic         po_busy,
    output logic         po_done
);

    localparam int         c_N    = 64 / LANES;
    localparam logic [5:0] c_LAST = 6'(c_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    state_t         r_fsm;
    state_t         w_fsm_next;
    logic           w_accept;
    logic           w_finish;
    logic           w_last;

    logic [127:0]   r_in;
    logic [127:0]   r_acc;
    logic [127:0]   r_out;
    logic [127:0]   w_acc_next;
    logic [5:0]     r_cnt;
    logic           r_busy;
    logic           r_done;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Coefficient multiplier: 00 = x1, 10 = x2, 11 = x3, 01 falls back to x1.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [1:0] code);
        logic [7:0] x2;
        x2 = xtime(b);
        case (code)
            2'b10:   return x2;
            2'b11:   return x2 ^ b;
            default: return b;
        endcase
    endfunction

    // Row 0 is {02,03,01,01}; row r is row 0 rotated right by r.
    function automatic logic [1:0] coef_code(input logic [1:0] r, input logic [1:0] t);
        logic [1:0] d;
        d = t - r;
        case (d)
            2'd0:    return 2'b10;
            2'd1:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    assign w_last = (r_cnt == c_LAST);

    // Products for this cycle's lanes folded into the accumulator.
    always_comb begin
        logic [5:0] w_p;
        logic [3:0] w_dst;
        logic [3:0] w_src;
        w_acc_next = r_acc;
        w_p        = 6'd0;
        w_dst      = 4'd0;
        w_src      = 4'd0;
        for (int l = 0; l < LANES; l++) begin
            w_p   = 6'(int'(r_cnt) * LANES + l);
            w_dst = w_p[5:2];
            w_src = {w_p[5:4], w_p[1:0]};
            w_acc_next[127 - 8*int'(w_dst) -: 8] = w_acc_next[127 - 8*int'(w_dst) -: 8]
                ^ gf_mul(r_in[127 - 8*int'(w_src) -: 8], coef_code(w_p[3:2], w_p[1:0]));
        end
    end

    // State register.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) r_fsm <= ST_IDLE;
        else        r_fsm <= w_fsm_next;
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        w_fsm_next = r_fsm;
        w_accept   = 1'b0;
        w_finish   = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (pi_start) begin
                    w_accept   = 1'b1;
                    w_fsm_next = pi_bypass ? ST_PASS : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_finish   = 1'b1;
                    w_fsm_next = ST_IDLE;
                end
            end
            ST_PASS: begin
                w_finish   = 1'b1;
                w_fsm_next = ST_IDLE;
            end
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    // Capture, accumulate and publish; the output register only moves on a
    // finishing edge so a partial accumulation is never visible.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            r_in   <= '0;
            r_acc  <= '0;
            r_out  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_in   <= pi_state;
                r_acc  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end
            if (r_fsm == ST_RUN) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_finish) begin
                r_busy <= 1'b0;
                r_out  <= (r_fsm == ST_PASS) ? r_in : w_acc_next;
            end
        end
    end

    assign po_state = r_out;
    assign po_busy  = r_busy;
    assign po_done  = r_done;

endmodule
`default_nettype wire
